// File: rtl/scratchpad_pkg.sv
// Shared scratchpad types: bank geometry, request/response payloads, slot states.
package scratchpad_pkg;

    localparam int unsigned SPAD_ADDR_W = 8;
    localparam int unsigned SPAD_DATA_W = 32;

    typedef logic [SPAD_ADDR_W-1:0] spad_addr_t;
    typedef logic [SPAD_DATA_W-1:0] spad_data_t;

    typedef struct packed {
        logic       we;
        spad_addr_t addr;
        spad_data_t wdata;
    } spad_req_t;

    typedef struct packed {
        logic       we;
        spad_data_t rdata;
    } spad_rsp_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/scratchpad_bank_if.sv
// Single-port scratchpad bank bus: controller issues ren/wen, bank answers one cycle later.
interface scratchpad_bank_if #(
    parameter int unsigned ADDR_W = scratchpad_pkg::SPAD_ADDR_W,
    parameter int unsigned DATA_W = scratchpad_pkg::SPAD_DATA_W
);
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport ctrl (output ren, output wen, output addr, output wdata,
                  input rdata, input rvalid);
    modport bank (input ren, input wen, input addr, input wdata,
                  output rdata, output rvalid);
endinterface

// File: rtl/scratchpad_rsp_slot.sv
// One-entry response register: filled by a bank capture, emptied by a client pop.
module scratchpad_rsp_slot
    import scratchpad_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  spad_rsp_t load_rsp,
    input  logic      pop,
    output logic      valid,
    output spad_rsp_t rsp
);

    slot_state_t state;
    slot_state_t state_next;
    logic        accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                    accept     = 1'b1;
                end
            end
            SLOT_FULL: begin
                if (pop) begin
                    state_next = load ? SLOT_FULL : SLOT_EMPTY;
                    accept     = load;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Payload only changes on an accepted load, so it holds while the client stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp <= '0;
        end else if (accept) begin
            rsp <= load_rsp;
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/scratchpad_bank_arbiter.sv
// Round-robin controller for one scratchpad bank: one access per cycle, one in flight,
// responses returned through per-client one-entry slots.
module scratchpad_bank_arbiter
    import scratchpad_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned ADDR_W      = SPAD_ADDR_W,
    parameter int unsigned DATA_W      = SPAD_DATA_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    scratchpad_bank_if.ctrl                     bank_if,
    input  logic [NUM_CLIENTS-1:0]              req_valid,
    output logic [NUM_CLIENTS-1:0]              req_ready,
    input  logic [NUM_CLIENTS-1:0]              req_we,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_CLIENTS-1:0]              rsp_valid,
    input  logic [NUM_CLIENTS-1:0]              rsp_ready,
    output logic [NUM_CLIENTS-1:0]              rsp_we,
    output logic [NUM_CLIENTS-1:0][DATA_W-1:0]  rsp_rdata,
    output logic                                err
);

    localparam int unsigned ID_W    = $clog2(NUM_CLIENTS);
    localparam int unsigned LAST_ID = NUM_CLIENTS - 1;

    // Returns {found, index} of the first set bit of elig scanning upward from start with wrap.
    function automatic logic [ID_W:0] rr_pick(input logic [ID_W-1:0]        start,
                                              input logic [NUM_CLIENTS-1:0] elig);
        logic [ID_W:0]        pick;
        logic [NUM_CLIENTS-1:0] shifted;
        int unsigned          idx;
        pick = '0;
        for (int unsigned off = 0; off < NUM_CLIENTS; off++) begin
            idx     = (32'(start) + off) % NUM_CLIENTS;
            shifted = elig >> idx;
            if (!pick[ID_W] && shifted[0]) begin
                pick = {1'b1, ID_W'(idx)};
            end
        end
        return pick;
    endfunction

    logic [ID_W-1:0]        prio;
    logic                   infl_valid;
    logic [ID_W-1:0]        infl_id;
    logic                   infl_we;
    logic [ADDR_W-1:0]      last_addr;
    logic [DATA_W-1:0]      last_wdata;

    logic [NUM_CLIENTS-1:0] eligible;
    logic [NUM_CLIENTS-1:0] slot_load;
    logic [ID_W:0]          pick;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    spad_rsp_t              cap_rsp;
    spad_rsp_t              slot_rsp [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        assign eligible[i]  = req_valid[i]
                            && !(infl_valid && (infl_id == ID_W'(i)))
                            && (!rsp_valid[i] || rsp_ready[i]);
        assign slot_load[i] = infl_valid && (infl_id == ID_W'(i));
        assign rsp_we[i]    = slot_rsp[i].we;
        assign rsp_rdata[i] = DATA_W'(slot_rsp[i].rdata);

        scratchpad_rsp_slot u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (slot_load[i]),
            .load_rsp (cap_rsp),
            .pop      (rsp_ready[i]),
            .valid    (rsp_valid[i]),
            .rsp      (slot_rsp[i])
        );
    end

    // Whatever the bank returns is captured even without rvalid; err flags the gap.
    assign cap_rsp = '{we: infl_we, rdata: SPAD_DATA_W'(bank_if.rdata)};

    // Grant and bank command in the same cycle; bus holds its last address/data when idle.
    always_comb begin
        pick          = rr_pick(prio, eligible);
        grant_valid   = rst_n && pick[ID_W];
        grant_id      = pick[ID_W-1:0];
        req_ready     = '0;
        bank_if.ren   = 1'b0;
        bank_if.wen   = 1'b0;
        bank_if.addr  = last_addr;
        bank_if.wdata = last_wdata;
        if (grant_valid) begin
            req_ready     = NUM_CLIENTS'(1) << grant_id;
            bank_if.ren   = !req_we[grant_id];
            bank_if.wen   = req_we[grant_id];
            bank_if.addr  = req_addr[grant_id];
            bank_if.wdata = req_wdata[grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio       <= '0;
            infl_valid <= 1'b0;
            infl_id    <= '0;
            infl_we    <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
            err        <= 1'b0;
        end else begin
            infl_valid <= grant_valid;
            if (grant_valid) begin
                infl_id    <= grant_id;
                infl_we    <= req_we[grant_id];
                last_addr  <= req_addr[grant_id];
                last_wdata <= req_wdata[grant_id];
                prio       <= (grant_id == ID_W'(LAST_ID)) ? '0 : grant_id + ID_W'(1);
            end
            if (infl_valid && !bank_if.rvalid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_bank_arbiter.sv
// Randomised and directed bench for scratchpad_bank_arbiter against a queue/array level model.
module tb_scratchpad_bank_arbiter;

    localparam int N = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N-1:0][7:0] req_addr;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [N-1:0]      rsp_we;
    logic [N-1:0][31:0] rsp_rdata;
    logic              err;
    logic              suppress;

    scratchpad_bank_if bif ();

    scratchpad_bank_arbiter #(.NUM_CLIENTS(N), .ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bank_if   (bif),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank: one-cycle read, write-through ack; suppress knocks out rvalid.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bif.wen) begin
            mem[bif.addr] <= bif.wdata;
            bif.rdata     <= bif.wdata;
        end else if (bif.ren) begin
            bif.rdata <= mem[bif.addr];
        end
        bif.rvalid <= (bif.ren | bif.wen) & ~suppress;
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          m_prio;
    bit          m_full [N];
    bit          m_we   [N];
    logic [31:0] m_data [N];
    bit          m_inf;
    int          m_inf_id;
    bit          m_inf_we;
    bit          m_inf_miss;
    logic [31:0] m_inf_data;
    bit          m_err;
    int          last_g;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_inf  = 0;
        m_err  = 0;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0;
            m_we[i]   = 0;
            m_data[i] = '0;
        end
    endtask

    // Compare every output with the model for the current inputs, then advance one cycle.
    task automatic step();
        bit elig [N];
        int g;
        #1;
        g = -1;
        for (int i = 0; i < N; i++) begin
            elig[i] = rst_n && req_valid[1'(i)] && !(m_inf && m_inf_id == i)
                      && (!m_full[i] || rsp_ready[1'(i)]);
        end
        for (int off = 0; off < N; off++) begin
            if (g < 0 && elig[(m_prio + off) % N]) g = (m_prio + off) % N;
        end
        last_g = g;
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'(0));
        check("ren", 64'(bif.ren), 64'(g >= 0 && !req_we[1'(g)]));
        check("wen", 64'(bif.wen), 64'(g >= 0 && req_we[1'(g)]));
        if (g >= 0) begin
            check("addr", 64'(bif.addr), 64'(req_addr[1'(g)]));
            if (req_we[1'(g)]) check("wdata", 64'(bif.wdata), 64'(req_wdata[1'(g)]));
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("rsp_valid%0d", i), 64'(rsp_valid[1'(i)]), 64'(m_full[i]));
            if (m_full[i]) begin
                check($sformatf("rsp_we%0d", i), 64'(rsp_we[1'(i)]), 64'(m_we[i]));
                check($sformatf("rsp_rdata%0d", i), 64'(rsp_rdata[1'(i)]), 64'(m_data[i]));
            end
        end
        check("err", 64'(err), 64'(m_err));

        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_full[i] && rsp_ready[1'(i)]) m_full[i] = 0;
            end
            if (m_inf) begin
                m_full[m_inf_id] = 1;
                m_we[m_inf_id]   = m_inf_we;
                m_data[m_inf_id] = m_inf_data;
                if (m_inf_miss) m_err = 1;
            end
            if (g >= 0) begin
                m_inf      = 1;
                m_inf_id   = g;
                m_inf_we   = req_we[1'(g)];
                m_inf_miss = suppress;
                if (m_inf_we) begin
                    m_inf_data                  = req_wdata[1'(g)];
                    ref_mem[req_addr[1'(g)]]    = req_wdata[1'(g)];
                end else begin
                    m_inf_data = ref_mem[req_addr[1'(g)]];
                end
                m_prio = (g + 1) % N;
            end else begin
                m_inf = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]     = 32'hC0DE_0000 | 32'(a);
            ref_mem[a] = 32'hC0DE_0000 | 32'(a);
        end
        mem[8'h10]     = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        rst_n     = 1'b0;
        suppress  = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        model_reset();
        @(negedge clk);
        repeat (3) step();

        // Reset values.
        rst_n = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata0", 64'(rsp_rdata[0]), 64'(0));
        check("rst_rsp_we", 64'(rsp_we), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        step();

        // Single read of 0x10 by client 0.
        req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 8'h10;
        #1;
        check("rd_ready", 64'(req_ready), 64'(2'b01));
        check("rd_ren", 64'(bif.ren), 64'(1));
        check("rd_addr", 64'(bif.addr), 64'(8'h10));
        step();
        req_valid = '0;
        step();
        check("rd_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        check("rd_rsp_data", 64'(rsp_rdata[0]), 64'(32'hDEAD_BEEF));
        check("rd_rsp_we", 64'(rsp_we[0]), 64'(0));
        rsp_ready = 2'b01;
        step();

        // Client 1 writes 0xFF, then reads it back.
        req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 8'hFF; req_wdata[1] = 32'hA5A5_0001;
        step();
        req_valid = '0;
        step();
        check("wr_ack_valid", 64'(rsp_valid[1]), 64'(1));
        check("wr_ack_we", 64'(rsp_we[1]), 64'(1));
        check("wr_ack_data", 64'(rsp_rdata[1]), 64'(32'hA5A5_0001));
        rsp_ready = 2'b11; req_valid = 2'b10; req_we = 2'b00;
        step();
        req_valid = '0; rsp_ready = 2'b00;
        step();
        check("rb_data", 64'(rsp_rdata[1]), 64'(32'hA5A5_0001));
        check("rb_we", 64'(rsp_we[1]), 64'(0));

        // Contention from prio 0: alternate grants, bank busy every cycle.
        rsp_ready = 2'b11; req_valid = 2'b11; req_we = 2'b00;
        req_addr[0] = 8'h03; req_addr[1] = 8'h04;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_grant", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            check("cont_busy", 64'(bif.ren | bif.wen), 64'(1));
            step();
        end

        // Backpressure on client 0 while client 1 keeps going.
        rsp_ready = 2'b10;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_blocked0", 64'(req_ready[0]), 64'(0));
            check("bp_hold0", 64'(rsp_rdata[0]), 64'(32'hC0DE_0003));
            step();
        end
        req_valid = 2'b01; rsp_ready = 2'b11; req_addr[0] = 8'h20;
        #1;
        check("bp_release", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0; rsp_ready = 2'b00;
        step();
        check("bp_refill_valid", 64'(rsp_valid[0]), 64'(1));
        check("bp_refill_data", 64'(rsp_rdata[0]), 64'(32'hC0DE_0020));

        // Missing rvalid makes err stick.
        rsp_ready = 2'b11; req_valid = 2'b01; req_addr[0] = 8'h10; suppress = 1'b1;
        step();
        suppress = 1'b0; req_valid = '0;
        step();
        check("miss_err", 64'(err), 64'(1));
        repeat (3) step();
        check("miss_err_sticky", 64'(err), 64'(1));

        // Reset the cycle after a grant.
        req_valid = 2'b10; req_addr[1] = 8'h11;
        step();
        rst_n = 1'b0; req_valid = 2'b11;
        #1;
        check("rstop_ready", 64'(req_ready), 64'(0));
        check("rstop_bus", 64'({bif.ren, bif.wen}), 64'(0));
        step();
        rst_n = 1'b1; req_valid = '0;
        step();
        step();
        check("rstop_no_rsp", 64'(rsp_valid), 64'(0));
        check("rstop_err", 64'(err), 64'(0));
        req_valid = 2'b11;
        #1;
        check("rstop_prio0", 64'(req_ready), 64'(2'b01));
        step();

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            suppress  = ($urandom_range(0, 149) == 0);
            req_valid = 2'($urandom);
            req_we    = 2'($urandom);
            rsp_ready = 2'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[1'(i)]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                req_wdata[1'(i)] = $urandom;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scratchpad_bank_arbiter.md
# scratchpad_bank_arbiter

Requester-side controller for one scratchpad bank: drives the controller end of `scratchpad_bank_if` (ren/wen/addr/wdata out, rdata/rvalid in) on behalf of `NUM_CLIENTS` independent requesters. Arbitrates round-robin, issues at most one bank access per cycle, tracks the single in-flight access, and returns each response into a per-client one-entry response slot with valid/ready backpressure. Sits between scratchpad clients (loader, host port) and the bank wrapper.

## Interface
- `NUM_CLIENTS`, 2, number of requesters (2..4)
- `ADDR_W`, 8, word address width (256 x 32-bit bank)
- `DATA_W`, 32, data width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `bank_if`  modport `ctrl`  -  `scratchpad_bank_if` controller end: drives `ren`, `wen`, `addr[ADDR_W-1:0]`, `wdata[DATA_W-1:0]`; samples `rdata[DATA_W-1:0]`, `rvalid`
- `req_valid`  in  NUM_CLIENTS  client request valid
- `req_ready`  out  NUM_CLIENTS  request accepted this cycle (one-hot or zero)
- `req_we`  in  NUM_CLIENTS  1 = write, 0 = read
- `req_addr`  in  NUM_CLIENTS x ADDR_W  word address
- `req_wdata`  in  NUM_CLIENTS x DATA_W  write data
- `rsp_valid`  out  NUM_CLIENTS  response slot full
- `rsp_ready`  in  NUM_CLIENTS  client consumes response
- `rsp_we`  out  NUM_CLIENTS  response is a write ack (rdata = written data, writethrough)
- `rsp_rdata`  out  NUM_CLIENTS x DATA_W  response data
- `err`  out  1  sticky protocol error: expected `rvalid` missing

## Operation
- Client i eligible iff `req_valid[i]`, no in-flight access for i, and slot i empty or popping this cycle (`rsp_valid[i] & rsp_ready[i]`).
- Round-robin: pointer `prio` names the highest-priority client; scan upward from `prio` with wrap; first eligible wins. On grant to k, `prio <= (k+1) mod NUM_CLIENTS`. No grant -> `prio` unchanged.
- Grant k: `req_ready[k]=1`; same cycle `ren = ~req_we[k]`, `wen = req_we[k]`, `addr/wdata` from client k. No grant: `ren=wen=0`, `addr/wdata` hold last value.
- In-flight register {valid, id, we} loaded on grant; cleared the next cycle.
- Cycle after grant: `rvalid` must be 1; `rdata` captured into slot[id] with `rsp_we=we`. If `rvalid=0` while in-flight valid: slot[id] still filled (data = `rdata`), `err <= 1`. Unexpected `rvalid` with no in-flight: ignored.
- Slot clears on `rsp_valid & rsp_ready`; capture into same slot same cycle is impossible by eligibility rule.
- States per slot: EMPTY -> (capture) FULL -> (pop) EMPTY.

## Timing
- Reset (`rst_n=0` at posedge): `prio=0`, in-flight invalid, all slots EMPTY, `err=0`, `rsp_rdata=0`, `rsp_we=0`; while low, `req_ready=0`, `ren=wen=0`. Access in flight at reset is dropped; no response.
- Latency: grant cycle N -> bank access N -> `rdata`/`rvalid` N+1 -> `rsp_valid` high from N+2.
- Per-client throughput: one access per 2 cycles; bank throughput: one per cycle with >=2 active clients.
- `req_ready` is combinational from `req_valid`, slot state, in-flight, `rsp_ready`, `prio`; no combinational path from bank `rdata`/`rvalid` to any output.
- `rsp_*` fully registered; hold stable while `rsp_valid & ~rsp_ready`.

## Structure
- `scratchpad_pkg`: `SPAD_ADDR_W`, `SPAD_DATA_W`, typedefs `spad_addr_t`, `spad_data_t`, struct `spad_req_t` {we, addr, wdata}, struct `spad_rsp_t` {we, rdata}.
- Sub-module `scratchpad_rsp_slot`: one-entry response register with load/pop, instantiated `NUM_CLIENTS` times.
- Round-robin pick is a function in the top module.

## Test plan
- Single read: bank word 0x10 = 0xDEADBEEF; client 0 reads 0x10 at cycle N -> `ren=1, addr=0x10` at N; `rsp_valid[0]=1, rsp_rdata[0]=0xDEADBEEF, rsp_we[0]=0` at N+2.
- Write then read: client 1 writes 0xA5A5_0001 to 0xFF -> ack with `rsp_we[1]=1`, data 0xA5A5_0001; subsequent read returns same value.
- Contention: both clients valid continuously, `prio=0` -> grants 0,1,0,1 on consecutive cycles; bank `ren|wen` high every cycle.
- Backpressure: `rsp_ready[0]=0` with slot full -> `req_ready[0]=0`, client 1 still granted; raise `rsp_ready[0]` -> client 0 granted same cycle, slot refilled 2 cycles later, data held stable meanwhile.
- Missing rvalid: bank model suppresses `rvalid` after grant -> `err=1` next cycle, stays 1 until reset.
- Reset mid-op: drop `rst_n` the cycle after a grant -> no `rsp_valid`, `err=0`, `prio=0`, `ren=wen=0`.
